// File: rtl/rob_pkg.sv
// Shared widths and entry layout for the reorder buffer.
package rob_pkg;

   localparam int unsigned TAG_W      = 32;
   localparam int unsigned REG_W      = 5;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned NUM_SEARCH = 4;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] val;
      logic              ready;
   } rob_entry_t;

endpackage

// File: rtl/rob_bypass_search.sv
// Youngest-match register search over the live window [head, head+count).
// With ROB_FINISH_FORWARD_EN, a same-cycle finish of the selected entry is forwarded.
module rob_bypass_search
   import rob_pkg::*;
#(
   parameter int unsigned SIZE = 16,
   localparam int unsigned PTR_W = $clog2(SIZE),
   localparam int unsigned CNT_W = $clog2(SIZE + 1)
) (
   input  logic [REG_W-1:0]  rd [SIZE],
   input  logic [DATA_W-1:0] val [SIZE],
   input  logic [SIZE-1:0]   ready,
`ifdef ROB_FINISH_FORWARD_EN
   input  logic [SIZE-1:0]   fin_hit,
   input  logic [DATA_W-1:0] finish_val,
`endif
   input  logic [PTR_W-1:0]  head,
   input  logic [CNT_W-1:0]  count,
   input  logic [REG_W-1:0]  rd_search,
   output logic [DATA_W-1:0] bypass_val
);

   int unsigned      slot;
   logic [PTR_W-1:0] idx;
   logic [PTR_W-1:0] sel;
   logic             hit;

   always_comb begin
      slot = 0;
      idx  = '0;
      sel  = '0;
      hit  = 1'b0;
      // Walk oldest to youngest so the last match wins.
      for (int unsigned k = 0; k < SIZE; k++) begin
         slot = 32'(head) + k;
         if (slot >= SIZE) slot = slot - SIZE;
         idx = PTR_W'(slot);
         if (k < 32'(count) && rd[idx] == rd_search) begin
            hit = 1'b1;
            sel = idx;
         end
      end
      bypass_val = '0;
      if (hit && rd_search != '0 && ready[sel]) bypass_val = val[sel];
`ifdef ROB_FINISH_FORWARD_EN
      if (hit && rd_search != '0 && fin_hit[sel]) bypass_val = finish_val;
`endif
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate/retire, finish by tag, flush by tag, 4 bypass ports.
// Optional macro ROB_FINISH_FORWARD_EN forwards same-cycle finishes to head and bypass outputs.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int unsigned SIZE = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [TAG_W-1:0]  instr_in,
   input  logic [REG_W-1:0]  rd_in,
   input  logic              pop,
   input  logic              finishing_instr,
   input  logic [TAG_W-1:0]  instr_to_finish,
   input  logic [DATA_W-1:0] finish_val,
   input  logic              flushing_instr,
   input  logic [TAG_W-1:0]  instr_to_flush,
   input  logic [REG_W-1:0]  rd_search_0,
   input  logic [REG_W-1:0]  rd_search_1,
   input  logic [REG_W-1:0]  rd_search_2,
   input  logic [REG_W-1:0]  rd_search_3,
   output logic [DATA_W-1:0] bypass_val_0,
   output logic [DATA_W-1:0] bypass_val_1,
   output logic [DATA_W-1:0] bypass_val_2,
   output logic [DATA_W-1:0] bypass_val_3,
   output logic [TAG_W-1:0]  head_instr,
   output logic [DATA_W-1:0] head_val,
   output logic              head_ready,
   output logic              is_full,
   output logic              is_empty
);

   localparam int unsigned PTR_W = $clog2(SIZE);
   localparam int unsigned CNT_W = $clog2(SIZE + 1);

   rob_entry_t       entries_q [SIZE];
   rob_entry_t       entries_d [SIZE];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [SIZE-1:0]   valid, fin_hit, ent_ready;
   logic [REG_W-1:0]  ent_rd [SIZE];
   logic [DATA_W-1:0] ent_val [SIZE];
   logic              push_ok, pop_ok, flush_hit;
   logic [PTR_W-1:0]  flush_idx;
   logic [CNT_W-1:0]  flush_off;
   int unsigned       age, slot;

   logic [REG_W-1:0]  search_rd [NUM_SEARCH];
   logic [DATA_W-1:0] bypass [NUM_SEARCH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == SIZE - 1) ? '0 : p + PTR_W'(1);
   endfunction

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_W'(SIZE));
   assign push_ok  = push && !is_full && !flushing_instr;
   assign pop_ok   = pop && !is_empty && head_ready;

   always_comb begin
      valid     = '0;
      fin_hit   = '0;
      flush_hit = 1'b0;
      flush_idx = '0;
      flush_off = '0;
      age       = 0;
      slot      = 0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         age = (i >= 32'(head_q)) ? i - 32'(head_q) : i + SIZE - 32'(head_q);
         valid[i]   = age < 32'(count_q);
         fin_hit[i] = valid[i] && finishing_instr && entries_q[i].tag == instr_to_finish;
      end
      // Youngest to oldest so the oldest matching entry is the flush point.
      for (int k = int'(SIZE) - 1; k >= 0; k--) begin
         slot = 32'(head_q) + 32'(k);
         if (slot >= SIZE) slot = slot - SIZE;
         if (32'(k) < 32'(count_q) && flushing_instr &&
             entries_q[PTR_W'(slot)].tag == instr_to_flush) begin
            flush_hit = 1'b1;
            flush_idx = PTR_W'(slot);
            flush_off = CNT_W'(k);
         end
      end
   end

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      for (int unsigned i = 0; i < SIZE; i++) begin
         if (fin_hit[i]) begin
            entries_d[i].ready = 1'b1;
            entries_d[i].val   = finish_val;
         end
      end
      if (pop_ok) begin
         head_d  = ptr_inc(head_q);
         count_d = count_q - CNT_W'(1);
      end
      if (flush_hit) begin
         tail_d = flush_idx;
         if (flush_off == '0) begin
            head_d  = flush_idx;
            count_d = '0;
         end else begin
            count_d = flush_off - CNT_W'(pop_ok);
         end
      end
      if (push_ok) begin
         entries_d[tail_q] = '{tag: instr_in, rd: rd_in, val: '0, ready: 1'b0};
         tail_d  = ptr_inc(tail_q);
         count_d = count_d + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < SIZE; i++) entries_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int unsigned i = 0; i < SIZE; i++) entries_q[i] <= entries_d[i];
      end
   end

   always_comb begin
      head_instr = '0;
      head_val   = '0;
      head_ready = 1'b0;
      if (!is_empty) begin
         head_instr = entries_q[head_q].tag;
         head_val   = entries_q[head_q].val;
         head_ready = entries_q[head_q].ready;
`ifdef ROB_FINISH_FORWARD_EN
         if (fin_hit[head_q]) begin
            head_val   = finish_val;
            head_ready = 1'b1;
         end
`endif
      end
   end

   for (genvar i = 0; i < SIZE; i++) begin : g_unpack
      assign ent_rd[i]    = entries_q[i].rd;
      assign ent_val[i]   = entries_q[i].val;
      assign ent_ready[i] = entries_q[i].ready;
   end

   assign search_rd[0] = rd_search_0;
   assign search_rd[1] = rd_search_1;
   assign search_rd[2] = rd_search_2;
   assign search_rd[3] = rd_search_3;
   assign bypass_val_0 = bypass[0];
   assign bypass_val_1 = bypass[1];
   assign bypass_val_2 = bypass[2];
   assign bypass_val_3 = bypass[3];

   for (genvar g = 0; g < NUM_SEARCH; g++) begin : g_search
      rob_bypass_search #(
         .SIZE(SIZE)
      ) u_search (
         .rd        (ent_rd),
         .val       (ent_val),
         .ready     (ent_ready),
`ifdef ROB_FINISH_FORWARD_EN
         .fin_hit   (fin_hit),
         .finish_val(finish_val),
`endif
         .head      (head_q),
         .count     (count_q),
         .rd_search (search_rd[g]),
         .bypass_val(bypass[g])
      );
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed plus randomized bench for reorder_buffer against a queue-based model.
module tb_reorder_buffer;

   localparam int unsigned SIZE = 10;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        push = 1'b0, pop = 1'b0, finishing_instr = 1'b0, flushing_instr = 1'b0;
   logic [31:0] instr_in = '0, instr_to_finish = '0, finish_val = '0, instr_to_flush = '0;
   logic [4:0]  rd_in = '0;
   logic [4:0]  rd_search_0 = '0, rd_search_1 = '0, rd_search_2 = '0, rd_search_3 = '0;
   logic [31:0] bypass_val_0, bypass_val_1, bypass_val_2, bypass_val_3;
   logic [31:0] head_instr, head_val;
   logic        head_ready, is_full, is_empty;

   always #5 clock = ~clock;

   reorder_buffer #(
      .SIZE(SIZE)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .push           (push),
      .instr_in       (instr_in),
      .rd_in          (rd_in),
      .pop            (pop),
      .finishing_instr(finishing_instr),
      .instr_to_finish(instr_to_finish),
      .finish_val     (finish_val),
      .flushing_instr (flushing_instr),
      .instr_to_flush (instr_to_flush),
      .rd_search_0    (rd_search_0),
      .rd_search_1    (rd_search_1),
      .rd_search_2    (rd_search_2),
      .rd_search_3    (rd_search_3),
      .bypass_val_0   (bypass_val_0),
      .bypass_val_1   (bypass_val_1),
      .bypass_val_2   (bypass_val_2),
      .bypass_val_3   (bypass_val_3),
      .head_instr     (head_instr),
      .head_val       (head_val),
      .head_ready     (head_ready),
      .is_full        (is_full),
      .is_empty       (is_empty)
   );

   typedef struct {
      logic [31:0] tag;
      logic [4:0]  rd;
      logic [31:0] val;
      logic        ready;
   } m_entry_t;

   m_entry_t mq[$];
   int       compared = 0;
   int       mismatched = 0;
   bit       model_valid = 1'b0;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
      end
   endtask

   function automatic logic fin_match(input logic [31:0] tag);
      return finishing_instr && tag == instr_to_finish;
   endfunction

   function automatic logic exp_head_ready();
      if (mq.size() == 0) return 1'b0;
`ifdef ROB_FINISH_FORWARD_EN
      if (fin_match(mq[0].tag)) return 1'b1;
`endif
      return mq[0].ready;
   endfunction

   function automatic logic [31:0] exp_head_val();
      if (mq.size() == 0) return '0;
`ifdef ROB_FINISH_FORWARD_EN
      if (fin_match(mq[0].tag)) return finish_val;
`endif
      return mq[0].val;
   endfunction

   function automatic logic [31:0] exp_bypass(input logic [4:0] rs);
      if (rs == 5'd0) return '0;
      for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
         if (mq[i].rd == rs) begin
`ifdef ROB_FINISH_FORWARD_EN
            if (fin_match(mq[i].tag)) return finish_val;
`endif
            return mq[i].ready ? mq[i].val : 32'd0;
         end
      end
      return '0;
   endfunction

   task automatic check_outputs();
      cmp("is_empty", 32'(is_empty), 32'(mq.size() == 0));
      cmp("is_full", 32'(is_full), 32'(mq.size() == SIZE));
      cmp("head_instr", head_instr, (mq.size() != 0) ? mq[0].tag : 32'd0);
      cmp("head_val", head_val, exp_head_val());
      cmp("head_ready", 32'(head_ready), 32'(exp_head_ready()));
      cmp("bypass_val_0", bypass_val_0, exp_bypass(rd_search_0));
      cmp("bypass_val_1", bypass_val_1, exp_bypass(rd_search_1));
      cmp("bypass_val_2", bypass_val_2, exp_bypass(rd_search_2));
      cmp("bypass_val_3", bypass_val_3, exp_bypass(rd_search_3));
   endtask

   // One clock of the model, using the inputs held across the edge.
   task automatic model_update();
      bit       push_ok, pop_ok;
      int       flush_pos;
      m_entry_t e;
      if (reset) begin
         mq.delete();
         model_valid = 1'b1;
         return;
      end
      push_ok   = push && mq.size() < SIZE && !flushing_instr;
      pop_ok    = pop && mq.size() > 0 && exp_head_ready();
      flush_pos = -1;
      if (flushing_instr) begin
         for (int i = 0; i < int'(mq.size()); i++) begin
            if (mq[i].tag == instr_to_flush) begin
               flush_pos = i;
               break;
            end
         end
      end
      foreach (mq[i]) begin
         if (fin_match(mq[i].tag)) begin
            mq[i].ready = 1'b1;
            mq[i].val   = finish_val;
         end
      end
      if (flush_pos >= 0) begin
         while (int'(mq.size()) > flush_pos) void'(mq.pop_back());
      end
      if (pop_ok && mq.size() > 0) void'(mq.pop_front());
      if (push_ok) begin
         e.tag = instr_in; e.rd = rd_in; e.val = '0; e.ready = 1'b0;
         mq.push_back(e);
      end
   endtask

   task automatic step();
      #3;
      if (model_valid) check_outputs();
      @(posedge clock);
      model_update();
      #1;
      reset = 1'b0; push = 1'b0; pop = 1'b0;
      finishing_instr = 1'b0; flushing_instr = 1'b0;
   endtask

   task automatic do_push(input logic [31:0] tag, input logic [4:0] rd);
      push = 1'b1; instr_in = tag; rd_in = rd;
      step();
   endtask

   task automatic do_finish(input logic [31:0] tag, input logic [31:0] v);
      finishing_instr = 1'b1; instr_to_finish = tag; finish_val = v;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
   endtask

   initial begin
      do_reset();
      do_reset();
      cmp("lit_reset_empty", 32'(is_empty), 32'd1);
      cmp("lit_reset_full", 32'(is_full), 32'd0);
      cmp("lit_reset_head", head_instr, 32'd0);
      cmp("lit_reset_bypass", bypass_val_0, 32'd0);

      // Fill, overflow attempt, then retire across the wrap point.
      for (int t = 1; t <= 10; t++) do_push(32'(t), 5'(t));
      cmp("lit_full_after_10", 32'(is_full), 32'd1);
      do_push(32'd11, 5'd11);
      cmp("lit_head_after_overflow", head_instr, 32'd1);
      cmp("lit_head_not_ready", 32'(head_ready), 32'd0);
      do_finish(32'd1, 32'd42);
      cmp("lit_head_ready_42", 32'(head_ready), 32'd1);
      cmp("lit_head_val_42", head_val, 32'd42);
      pop = 1'b1; step();
      cmp("lit_head_after_pop", head_instr, 32'd2);
      cmp("lit_not_full_after_pop", 32'(is_full), 32'd0);
      pop = 1'b1; step();
      cmp("lit_pop_not_ready", head_instr, 32'd2);
      for (int t = 11; t <= 15; t++) begin
         do_finish(mq[0].tag, 32'(t * 3));
         push = 1'b1; instr_in = 32'(t); rd_in = 5'(t); pop = 1'b1;
         step();
      end
      cmp("lit_head_after_wrap", head_instr, 32'd7);

      // Bypass picks youngest matching rd.
      do_reset();
      rd_search_0 = 5'd3; rd_search_1 = 5'd0; rd_search_2 = 5'd4; rd_search_3 = 5'd9;
      do_push(32'd5, 5'd3);
      do_push(32'd6, 5'd3);
      do_push(32'd7, 5'd4);
      do_finish(32'd5, 32'd100);
      cmp("lit_bypass_rd3_young_not_ready", bypass_val_0, 32'd0);
      do_finish(32'd6, 32'd200);
      cmp("lit_bypass_rd3_200", bypass_val_0, 32'd200);
      cmp("lit_bypass_rd0", bypass_val_1, 32'd0);
      cmp("lit_bypass_rd4_not_ready", bypass_val_2, 32'd0);

      // Flush overrides push; squash back to the flush point.
      do_reset();
      for (int t = 20; t <= 24; t++) do_push(32'(t), 5'(t));
      flushing_instr = 1'b1; instr_to_flush = 32'd22;
      push = 1'b1; instr_in = 32'd25; rd_in = 5'd25;
      step();
      cmp("lit_flush_head", head_instr, 32'd20);
      do_push(32'd26, 5'd26);
      do_finish(32'd20, 32'd1);
      do_finish(32'd21, 32'd2);
      pop = 1'b1; step();
      pop = 1'b1; step();
      cmp("lit_push_after_flush", head_instr, 32'd26);
      flushing_instr = 1'b1; instr_to_flush = 32'd26;
      step();
      cmp("lit_flush_head_empty", 32'(is_empty), 32'd1);

      // Same-cycle finish visibility on the head.
      do_reset();
      do_push(32'd30, 5'd1);
      finishing_instr = 1'b1; instr_to_finish = 32'd30; finish_val = 32'd7;
      #3;
`ifdef ROB_FINISH_FORWARD_EN
      cmp("lit_fwd_head_val", head_val, 32'd7);
      cmp("lit_fwd_head_ready", 32'(head_ready), 32'd1);
`else
      cmp("lit_nofwd_head_val", head_val, 32'd0);
      cmp("lit_nofwd_head_ready", 32'(head_ready), 32'd0);
`endif
      @(posedge clock);
      model_update();
      #1;
      finishing_instr = 1'b0;
      cmp("lit_next_head_val", head_val, 32'd7);
      cmp("lit_next_head_ready", 32'(head_ready), 32'd1);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         reset           = ($urandom_range(0, 399) == 0);
         push            = ($urandom_range(0, 99) < 60);
         instr_in        = 32'($urandom_range(1, 30));
         rd_in           = 5'($urandom_range(0, 7));
         pop             = ($urandom_range(0, 99) < 45);
         finishing_instr = ($urandom_range(0, 99) < 45);
         finish_val      = $urandom;
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            instr_to_finish = mq[$urandom_range(0, mq.size() - 1)].tag;
         else
            instr_to_finish = 32'($urandom_range(1, 30));
         flushing_instr = ($urandom_range(0, 99) < 6);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            instr_to_flush = mq[$urandom_range(0, mq.size() - 1)].tag;
         else
            instr_to_flush = 32'($urandom_range(1, 30));
         rd_search_0 = 5'($urandom_range(0, 7));
         rd_search_1 = 5'($urandom_range(0, 7));
         rd_search_2 = 5'($urandom_range(0, 7));
         rd_search_3 = 5'($urandom_range(0, 7));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
